// File: rtl/modmul_pkg.sv
// Shared definitions for the modmul_seq engine.
//   state_t  : controller states (IDLE, MUL, DONE)
//   OP_MUL / OP_ADD : encoding of the op request field
//   wide_t   : widest intermediate (MAX_W+1 bits) used by the reduce helper
//   reduce() : single conditional subtraction, t >= n ? t - n : t
package modmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam int unsigned MAX_W = 32;

  typedef logic [MAX_W:0] wide_t;

  // Brings a value in [0, 2n) back into [0, n).
  function automatic wide_t reduce(input wide_t t, input wide_t n);
    return (t >= n) ? t - n : t;
  endfunction

endpackage

// File: rtl/modmul_step.sv
// One interleaved multiply step: next = ((2*acc mod n) + b_bit*a) mod n.
// Combinational; requires acc < n and a < n so one subtraction per stage suffices.
//   acc   : running accumulator (W)
//   a     : multiplicand (W)
//   n     : modulus (W)
//   b_bit : current multiplier bit, MSB first
//   next  : updated accumulator (W)
module modmul_step
  import modmul_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] n,
  input  logic         b_bit,
  output logic [W-1:0] next
);

  logic [W:0] dbl;
  wide_t      addend;

  always_comb begin
    dbl    = (W+1)'(reduce(wide_t'({acc, 1'b0}), wide_t'(n)));
    addend = b_bit ? wide_t'(a) : '0;
    next   = W'(reduce(wide_t'(dbl) + addend, wide_t'(n)));
  end

endmodule

// File: rtl/modmul_seq.sv
// Sequential modular engine: c = a*b mod n (op=0, one multiplier bit per
// cycle, MSB first) or c = (a+b) mod n (op=1, single cycle).
// Requests with n==0, a>=n or b>=n are rejected with err=1, c=0.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : request handshake; in_ready high only in IDLE
//   op, a, b, n     : request fields, sampled on acceptance only
//   out_valid/ready : result handshake; c/err held while out_valid
//   busy            : high while the multiply loop runs
module modmul_seq
  import modmul_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         err,
  output logic         busy
);

  localparam int unsigned IW = $clog2(W);

  state_t          state, state_nx;
  logic [W-1:0]    a_r, b_r, n_r, acc_r, c_r;
  logic [IW-1:0]   idx_r;
  logic            err_r;
  logic            accept;
  logic            range_err;
  logic [W-1:0]    step_next;

  assign accept    = in_valid && (state == IDLE);
  assign range_err = (n == '0) || (a >= n) || (b >= n);

  modmul_step #(.W(W)) u_step (
    .acc   (acc_r),
    .a     (a_r),
    .n     (n_r),
    .b_bit (b_r[idx_r]),
    .next  (step_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (!range_err && op == OP_MUL) ? MUL : DONE;
      MUL:  if (idx_r == '0) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == MUL);
    out_valid = (state == DONE);
    c         = c_r;
    err       = err_r;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      n_r   <= '0;
      acc_r <= '0;
      idx_r <= '0;
      c_r   <= '0;
      err_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          a_r   <= a;
          b_r   <= b;
          n_r   <= n;
          acc_r <= '0;
          idx_r <= IW'(W - 1);
          err_r <= range_err;
          if (range_err)        c_r <= '0;
          else if (op == OP_ADD) c_r <= W'(reduce(wide_t'(a) + wide_t'(b), wide_t'(n)));
          else                   c_r <= '0;
        end
        MUL: begin
          acc_r <= step_next;
          idx_r <= idx_r - 1'b1;
          if (idx_r == '0) c_r <= step_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modmul_seq.sv
module tb_modmul_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // W=8 instance
  logic       in_valid8, in_ready8, op8, out_valid8, out_ready8, err8, busy8;
  logic [7:0] a8, b8, n8, c8;

  // W=16 instance
  logic        in_valid16, in_ready16, op16, out_valid16, out_ready16, err16, busy16;
  logic [15:0] a16, b16, n16, c16;

  int errors = 0;
  int checks = 0;

  modmul_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .n(n8), .out_valid(out_valid8), .out_ready(out_ready8),
    .c(c8), .err(err8), .busy(busy8)
  );

  modmul_seq #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .n(n16), .out_valid(out_valid16), .out_ready(out_ready16),
    .c(c16), .err(err16), .busy(busy16)
  );

  // Issue one request to dut8, wait for out_valid (bounded). Leaves result pending.
  task automatic run8(input logic op_i, input logic [7:0] ai, input logic [7:0] bi,
                      input logic [7:0] ni, output logic [7:0] c_o, output logic e_o,
                      output int lat, output int bc);
    @(posedge clk); #1;
    op8 = op_i; a8 = ai; b8 = bi; n8 = ni; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'hA5; b8 = 8'h5A; n8 = 8'h33; op8 = ~op_i;  // must be ignored now
    lat = 1; bc = 0;
    while (!out_valid8 && lat < 60) begin
      if (busy8) bc++;
      @(posedge clk); #1;
      lat++;
    end
    c_o = c8; e_o = err8;
  endtask

  task automatic finish8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic run16(input logic op_i, input logic [15:0] ai, input logic [15:0] bi,
                       input logic [15:0] ni, output logic [15:0] c_o, output logic e_o,
                       output int lat);
    @(posedge clk); #1;
    op16 = op_i; a16 = ai; b16 = bi; n16 = ni; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    c_o = c16; e_o = err16;
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid8 = 0; op8 = 0; a8 = 0; b8 = 0; n8 = 0; out_ready8 = 0;
    in_valid16 = 0; op16 = 0; a16 = 0; b16 = 0; n16 = 0; out_ready16 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({in_ready8, out_valid8, busy8, err8, c8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b err=%b c=%0d, want 1 0 0 0 0",
               in_ready8, out_valid8, busy8, err8, c8);
    end
  endtask

  task automatic test_mul_basic();
    logic [7:0] c; logic e; int lat, bc;
    run8(1'b0, 8'd7, 8'd9, 8'd11, c, e, lat, bc);
    checks++; if (c !== 8'd8) begin errors++; $display("FAIL mul_7x9: c=%0d want 8", c); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL mul_7x9_err: err=%b want 0", e); end
    checks++; if (lat != 9) begin errors++; $display("FAIL mul_latency: got %0d want 9", lat); end
    checks++; if (bc != 8) begin errors++; $display("FAIL mul_busy: got %0d cycles want 8", bc); end
    finish8();
    checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++; $display("FAIL mul_return_idle: in_ready=%b out_valid=%b want 1 0", in_ready8, out_valid8);
    end
  endtask

  task automatic test_mul_wrap();
    logic [7:0] c; logic e; int lat, bc;
    run8(1'b0, 8'd250, 8'd250, 8'd251, c, e, lat, bc);
    checks++; if (c !== 8'd1 || e !== 1'b0) begin
      errors++; $display("FAIL mul_250x250: c=%0d err=%b want 1 0", c, e);
    end
    finish8();
  endtask

  task automatic test_add();
    logic [7:0] c; logic e; int lat, bc;
    run8(1'b1, 8'd200, 8'd100, 8'd251, c, e, lat, bc);
    checks++; if (c !== 8'd49 || e !== 1'b0) begin
      errors++; $display("FAIL add_200_100: c=%0d err=%b want 49 0", c, e);
    end
    checks++; if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
    finish8();
    run8(1'b1, 8'd3, 8'd4, 8'd11, c, e, lat, bc);
    checks++; if (c !== 8'd7) begin errors++; $display("FAIL add_no_wrap: c=%0d want 7", c); end
    finish8();
  endtask

  task automatic test_errors();
    logic [7:0] c; logic e; int lat, bc;
    run8(1'b0, 8'd0, 8'd0, 8'd0, c, e, lat, bc);
    checks++; if (e !== 1'b1 || c !== 8'd0) begin
      errors++; $display("FAIL err_n0: err=%b c=%0d want 1 0", e, c);
    end
    checks++; if (lat != 1) begin errors++; $display("FAIL err_n0_latency: got %0d want 1", lat); end
    finish8();
    run8(1'b0, 8'd12, 8'd3, 8'd11, c, e, lat, bc);
    checks++; if (e !== 1'b1 || c !== 8'd0 || lat != 1) begin
      errors++; $display("FAIL err_a_ge_n: err=%b c=%0d lat=%0d want 1 0 1", e, c, lat);
    end
    finish8();
    run8(1'b1, 8'd3, 8'd11, 8'd11, c, e, lat, bc);
    checks++; if (e !== 1'b1 || c !== 8'd0) begin
      errors++; $display("FAIL err_b_ge_n: err=%b c=%0d want 1 0", e, c);
    end
    finish8();
    run8(1'b0, 8'd0, 8'd0, 8'd1, c, e, lat, bc);
    checks++; if (e !== 1'b0 || c !== 8'd0 || lat != 9) begin
      errors++; $display("FAIL n1_edge: err=%b c=%0d lat=%0d want 0 0 9", e, c, lat);
    end
    finish8();
  endtask

  task automatic test_backpressure();
    logic [7:0] c; logic e; int lat, bc;
    run8(1'b0, 8'd7, 8'd9, 8'd11, c, e, lat, bc);
    in_valid8 = 1'b1; op8 = 1'b1; a8 = 8'd1; b8 = 8'd1; n8 = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || c8 !== 8'd8 || err8 !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b c=%0d err=%b want 1 0 8 0",
                 i, out_valid8, in_ready8, c8, err8);
      end
    end
    in_valid8 = 1'b0;
    finish8();
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                         in_ready8, out_valid8, busy8);
    end
  endtask

  task automatic test_early_ready();
    int waited;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    op8 = 1'b0; a8 = 8'd5; b8 = 8'd6; n8 = 8'd13; in_valid8 = 1'b1;  // 30 mod 13 = 4
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    waited = 1;
    while (!out_valid8 && waited < 60) begin @(posedge clk); #1; waited++; end
    checks++;
    if (out_valid8 !== 1'b1 || c8 !== 8'd4 || waited != 9) begin
      errors++; $display("FAIL early_ready: out_valid=%b c=%0d lat=%0d want 1 4 9", out_valid8, c8, waited);
    end
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++; $display("FAIL early_ready_idle: out_valid=%b in_ready=%b want 0 1", out_valid8, in_ready8);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] c; logic e; int lat, bc;
    @(posedge clk); #1;
    op8 = 1'b0; a8 = 8'd7; b8 = 8'd9; n8 = 8'd11; in_valid8 = 1'b1;
    @(posedge clk); #1;      // first MUL cycle
    in_valid8 = 1'b0;
    @(posedge clk); #1;      // second
    @(posedge clk); #1;      // third
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL reset_mid_busy: busy=%b want 1", busy8); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || in_ready8 !== 1'b1 || c8 !== 8'd0) begin
      errors++; $display("FAIL reset_mid_state: out_valid=%b busy=%b in_ready=%b c=%0d want 0 0 1 0",
                         out_valid8, busy8, in_ready8, c8);
    end
    run8(1'b0, 8'd7, 8'd9, 8'd11, c, e, lat, bc);
    checks++; if (c !== 8'd8 || lat != 9) begin
      errors++; $display("FAIL reset_mid_rerun: c=%0d lat=%0d want 8 9", c, lat);
    end
    finish8();
  endtask

  task automatic test_w16();
    logic [15:0] c; logic e; int lat;
    logic [15:0] ra, rb, rn;
    logic        rop;
    longint unsigned expv;
    run16(1'b0, 16'd65520, 16'd65520, 16'd65521, c, e, lat);
    checks++; if (c !== 16'd1 || e !== 1'b0 || lat != 17) begin
      errors++; $display("FAIL w16_mul: c=%0d err=%b lat=%0d want 1 0 17", c, e, lat);
    end
    for (int i = 0; i < 1000; i++) begin
      rn  = 16'($urandom_range(1, 65535));
      ra  = 16'($urandom % rn);
      rb  = 16'($urandom % rn);
      rop = 1'($urandom_range(0, 1));
      if (rop) expv = (longint'(ra) + longint'(rb)) % longint'(rn);
      else     expv = (longint'(ra) * longint'(rb)) % longint'(rn);
      run16(rop, ra, rb, rn, c, e, lat);
      checks++;
      if (c !== 16'(expv) || e !== 1'b0) begin
        errors++;
        $display("FAIL w16_rand[%0d] op=%0d a=%0d b=%0d n=%0d: c=%0d err=%b want %0d 0",
                 i, rop, ra, rb, rn, c, e, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_wrap();
    test_add();
    test_errors();
    test_backpressure();
    test_early_ready();
    test_reset_mid_op();
    test_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
